// File: rtl/ha_array_mul_seq_if.sv
// Handshake bundle between the requesting datapath and ha_array_mul_seq.
//   in_valid/in_ready/in_x/in_y     : operand pair request channel
//   out_valid/out_ready/out_p/out_sat : product response channel
// master = requester side, slave = controller side.
interface ha_array_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_sat;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p, out_sat
  );
endinterface

// File: rtl/ha_array_mul_seq.sv
// Sequencing controller for the ha_array partial-product stage of the 8x8
// approximate multiplier. Accepts an operand pair, drives it to the stage,
// captures the four row pairs, accumulates them into a saturated 16-bit
// product over 4/ROWS_PER_CYCLE cycles and returns it over a handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : in_valid/in_ready/in_x/in_y, out_valid/out_ready/out_p/out_sat
//   flush             : synchronous abort of the operation in flight
//   op_x, op_y        : operands held for the ha_array stage
//   ha_b0..3, ha_t0..3: row vectors returned by the stage (sampled in CAPT)
//   busy              : controller not idle
//   op_count          : consumed products, wrapping
module ha_array_mul_seq #(
  parameter int unsigned ROWS_PER_CYCLE = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ha_array_mul_seq_if.slave    bus,
  input  logic                 flush,
  output logic [7:0]           op_x,
  output logic [7:0]           op_y,
  input  logic [6:0]           ha_b0,
  input  logic [6:0]           ha_b1,
  input  logic [6:0]           ha_b2,
  input  logic [6:0]           ha_b3,
  input  logic [8:0]           ha_t0,
  input  logic [8:0]           ha_t1,
  input  logic [8:0]           ha_t2,
  input  logic [8:0]           ha_t3,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int unsigned ACC_W = 17;
  localparam int unsigned ROW_W = 10;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [6:0]       cap_b [4];
  logic [8:0]       cap_t [4];
  logic [ACC_W-1:0] acc_q;
  logic [1:0]       row_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c;
  logic             consume_c;
  logic             last_c;
  logic [ACC_W-1:0] add_c;
  logic [1:0]       k_c;
  logic [ROW_W-1:0] row_c;

  // Ready drops while flushing so a same-cycle handshake is never taken.
  assign bus.in_ready = !flush &&
                        ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign consume_c    = (state_q == S_DONE) && bus.out_ready && !flush;
  // Row base of the final ACC step; rows 4-ROWS_PER_CYCLE..3 finish the sum.
  assign last_c       = (row_q == 2'(4 - ROWS_PER_CYCLE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept_c) state_d = S_CAPT;
        S_CAPT: state_d = S_ACC;
        S_ACC:  if (last_c) state_d = S_DONE;
        S_DONE: if (consume_c) state_d = accept_c ? S_CAPT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sum of the rows handled this ACC step: R_k = (t_k + 4*b_k) << 2k.
  always_comb begin
    add_c = '0;
    k_c   = '0;
    row_c = '0;
    for (int unsigned i = 0; i < ROWS_PER_CYCLE; i++) begin
      k_c   = 2'(row_q + 2'(i));
      row_c = ROW_W'(cap_t[k_c]) + ROW_W'({cap_b[k_c], 2'b00});
      add_c = add_c + (ACC_W'(row_c) << {k_c, 1'b0});
    end
  end

  // Operand, capture, accumulator and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x  <= '0;
      op_y  <= '0;
      acc_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cap_b[i] <= '0;
        cap_t[i] <= '0;
      end
    end else begin
      if (accept_c) begin
        op_x <= bus.in_x;
        op_y <= bus.in_y;
      end
      if (consume_c) cnt_q <= cnt_q + CNT_W'(1);
      if (flush) begin
        acc_q <= '0;
        row_q <= '0;
      end else if (state_q == S_CAPT) begin
        cap_b[0] <= ha_b0;
        cap_b[1] <= ha_b1;
        cap_b[2] <= ha_b2;
        cap_b[3] <= ha_b3;
        cap_t[0] <= ha_t0;
        cap_t[1] <= ha_t1;
        cap_t[2] <= ha_t2;
        cap_t[3] <= ha_t3;
        acc_q    <= '0;
        row_q    <= '0;
      end else if (state_q == S_ACC) begin
        acc_q <= acc_q + add_c;
        row_q <= 2'(row_q + 2'(ROWS_PER_CYCLE));
      end
    end
  end

  // Outputs are decodes of registered state only.
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sat   = acc_q[ACC_W-1];
  assign bus.out_p     = acc_q[ACC_W-1] ? 16'hFFFF : acc_q[15:0];
  assign busy          = (state_q != S_IDLE);
  assign op_count      = cnt_q;

endmodule

// File: doc/ha_array_mul_seq.md
Name: ha_array_mul_seq

Overview:
- Sequencing controller for the 8x8 unsigned approximate multiplier's half-adder partial-product stage.
- Accepts operand pairs over a valid/ready handshake and drives them to the combinational ha_array stage.
- Registers the four ha_array row pairs, then accumulates them into a 16-bit product over a configurable number of cycles.
- Returns the result over a second valid/ready handshake.
- Sits between the requesting datapath and the ha_array instance, letting the final adder tree be shared or time-multiplexed.

Parameters:
- ROWS_PER_CYCLE, 1: rows accumulated per ACC cycle; legal values 1, 2, 4; N_ACC = 4/ROWS_PER_CYCLE.
- CNT_W, 16: width of op_count.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_x  in  8  multiplicand
- in_y  in  8  multiplier
- flush  in  1  synchronous abort of the operation in flight
- op_x  out  8  operand x driven to ha_array stage (registered)
- op_y  out  8  operand y driven to ha_array stage (registered)
- ha_b0, ha_b1, ha_b2, ha_b3  in  7 each  ha_array_k_b returned by the stage
- ha_t0, ha_t1, ha_t2, ha_t3  in  9 each  ha_array_k_t returned by the stage
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  16  product, saturated
- out_sat  out  1  saturation occurred for the current out_p
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed (consumed) products, wrapping

Behaviour:
- Row value: R_k = (t_k + (b_k << 2)) << (2k), with t_k zero-extended and sum width 10 bits before the shift.
- Accumulator: 17 bits, cleared on capture.
- out_p = (acc[16] ? 16'hFFFF : acc[15:0]); out_sat = acc[16].
- FSM states:
  - IDLE: in_ready=1. On in_valid: register in_x/in_y into op_x/op_y, go to CAPT.
  - CAPT: one cycle, gives the stage a full cycle to settle. At the edge, register all eight ha vectors, clear acc and row counter, go to ACC.
  - ACC: each edge adds ROWS_PER_CYCLE rows in ascending k. After N_ACC edges, go to DONE.
  - DONE: out_valid=1, holding out_p/out_sat stable. On out_ready: op_count += 1.
    - If in_valid is also high, load new operands and go directly to CAPT (zero-bubble back-to-back).
    - Otherwise go to IDLE.
- Ready and latency:
  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational on out_ready only.
  - out_valid rises N_ACC+1 cycles after the accepting edge: 5 for ROWS_PER_CYCLE=1, 3 for 2, 2 for 4.
  - Throughput is one product per N_ACC+2 cycles.
- op_x/op_y are held constant from the accepting edge until the next accept; they are not cleared on completion.
- flush:
  - From any state, the next edge goes to IDLE and clears out_valid, acc, out_sat and the row counter.
  - A handshake in the same cycle as flush is ignored (in_ready forced 0 while flush=1).
  - If flush=1 while out_valid & out_ready, the product is not counted.
  - op_x/op_y keep their values.
- Reset (rst=1 at edge), highest priority:
  - state=IDLE, op_x=0, op_y=0, out_valid=0, out_p=0, out_sat=0, busy=0, op_count=0, all captured vectors and acc=0.
  - Reset mid-operation discards the operation.
- op_count wraps from 2^CNT_W-1 to 0.
- Inputs ha_* are sampled only in CAPT; changes at other times have no effect.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, in_ready=1, op_count=0, out_p=0, busy=0.
- Single row weights, ROWS_PER_CYCLE=1:
  - ha_t0=1, rest 0 -> out_p=1 at accept+5.
  - ha_b0=1 only -> 4.
  - ha_t3=1 only -> 64.
  - ha_b3=7'h40 only -> 16384.
  - out_sat=0 in all four cases.
- Saturation: all ha_t=9'h1FF, all ha_b=7'h7F -> acc=1019*85=86615 -> out_p=16'hFFFF, out_sat=1.
- Back-to-back: out_ready and in_valid both high in DONE -> new op in CAPT next cycle, no IDLE cycle, op_count increments by 1 per consumed product. out_ready held low 10 cycles -> out_p stable, in_ready=0.
- Flush and reset mid-op:
  - flush in ACC cycle 2 -> IDLE next cycle, no out_valid, op_count unchanged.
  - rst in CAPT -> all outputs at reset values.
  - Next operation yields the correct fresh result (no residue in acc).
- Parameter sweep: ROWS_PER_CYCLE=2 and 4 on the same vectors give identical out_p, with out_valid latency 3 and 2 respectively.
